if_stage: RTL

- Instruction-fetch stage of the 5-stage pipelined minicpu. It sits directly upstream of the decode stage.
- Owns the PC and drives the synchronous instruction SRAM (1-cycle read latency).
- Hands {inst, pc} to decode through a valid/allowin handshake.
- Accepts branch redirects from decode and cancels the wrong-path instruction it currently holds.

---
 rtl/if_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle instruction SRAM and hands {inst, pc} to decode.
// Build option IF_ADEF_EN adds the misaligned-fetch (adef) flag as the bus MSB and suppresses misaligned reads.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          BR_BUS_WD = 33
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ds_allowin,
    input  logic [BR_BUS_WD-1:0] br_bus,
    output logic                 fs_to_ds_valid,
`ifdef IF_ADEF_EN
    output logic [64:0]          fs_to_ds_bus,
`else
    output logic [63:0]          fs_to_ds_bus,
`endif
    output logic                 inst_sram_en,
    output logic                 inst_sram_we,
    output logic [31:0]          inst_sram_addr,
    output logic [31:0]          inst_sram_wdata,
    input  logic [31:0]          inst_sram_rdata
);

    // Handshake: decode consumes an instruction on a rising edge where
    // fs_to_ds_valid && ds_allowin; the bus is held stable while valid && !ds_allowin.

    localparam logic [31:0] NOP_INST = 32'h03400000;

    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        to_fs_valid;
    logic        fs_allowin;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    assign br_taken    = br_bus[BR_BUS_WD-1];
    assign br_target   = br_bus[31:0];
    assign to_fs_valid = resetn;
    assign seq_pc      = fs_pc_q + 32'd4;
    assign nextpc      = br_taken ? br_target : seq_pc;
    // A taken branch kills the held instruction, so it also frees the stage.
    assign fs_allowin  = !fs_valid_q || ds_allowin || br_taken;

    assign inst_sram_we    = 1'b0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = nextpc;

`ifdef IF_ADEF_EN
    logic adef;
    assign adef         = (fs_pc_q[1:0] != 2'b00);
    assign inst_sram_en = to_fs_valid && fs_allowin && (nextpc[1:0] == 2'b00);
    assign fs_inst      = adef ? NOP_INST : (inst_buf_valid_q ? inst_buf_q : inst_sram_rdata);
    assign fs_to_ds_bus = {adef, fs_inst, fs_pc_q};
`else
    assign inst_sram_en = to_fs_valid && fs_allowin;
    assign fs_inst      = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
    assign fs_to_ds_bus = {fs_inst, fs_pc_q};
`endif

    assign fs_to_ds_valid = fs_valid_q && !br_taken;

    always_comb begin
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;
        if (fs_allowin) begin
            fs_valid_d       = 1'b1;
            fs_pc_d          = nextpc;
            inst_buf_valid_d = 1'b0;
        end else if (!inst_buf_valid_q) begin
            // SRAM output is only guaranteed for one cycle; keep a copy while stalled.
            inst_buf_d       = inst_sram_rdata;
            inst_buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= RESET_PC - 32'd4;
            inst_buf_q       <= 32'h0;
            inst_buf_valid_q <= 1'b0;
        end else begin
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            inst_buf_q       <= inst_buf_d;
            inst_buf_valid_q <= inst_buf_valid_d;
        end
    end

endmodule
